// File: rtl/crc_eng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crc_eng_pkg
//  Purpose  : CRC32C engine register map, opcodes, status codes and FSM states
//  Revision : 1.0
// ============================================================================
package crc_eng_pkg;

    localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;

    localparam logic [15:0] ADDR_IN     = 16'h0640;
    localparam logic [15:0] ADDR_STATUS = 16'h0648;
    localparam logic [15:0] ADDR_RESULT = 16'h0650;
    localparam logic [15:0] ADDR_CTRL   = 16'h0658;

    localparam logic [31:0] CTRL_PUT = 32'd1;
    localparam logic [31:0] CTRL_GET = 32'd2;
    localparam logic [31:0] CTRL_CLR = 32'd3;

    localparam logic [31:0] STAT_BUSY  = 32'd0;
    localparam logic [31:0] STAT_READ  = 32'd1;
    localparam logic [31:0] STAT_FULL  = 32'd2;
    localparam logic [31:0] STAT_READY = 32'd3;
    localparam logic [31:0] STAT_ERROR = 32'd4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLR_WR   = 4'd1,
        ST_GAP      = 4'd2,
        ST_IN_WAIT  = 4'd3,
        ST_IN_WR    = 4'd4,
        ST_PUT_WR   = 4'd5,
        ST_GET_WR   = 4'd6,
        ST_POLL_RD  = 4'd7,
        ST_POLL_CHK = 4'd8,
        ST_RES_RD   = 4'd9,
        ST_DONE     = 4'd10
    } seq_state_t;

    // Index wrap for values below 2*n (round-robin arithmetic).
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : crc_bus_master
//  Purpose  : two-cycle strobe/hold register bus master for the CRC engine
//  Revision : 1.0
// ============================================================================
module crc_bus_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rd_valid,
    output logic [31:0] rdata,
    output logic [15:0] eng_addr,
    output logic [31:0] eng_wdata,
    output logic        eng_wr,
    output logic        eng_rd,
    input  logic [31:0] eng_rdata
);

    logic        r_hold;
    logic        r_is_write;
    logic [15:0] r_addr;
    logic [31:0] r_data;
    logic        w_accept;

    // Strobe cycle is the accept cycle; the hold cycle replays the latched address.
    assign cmd_ready = !r_hold;
    assign w_accept  = cmd_valid && !r_hold;
    assign eng_wr    = w_accept && cmd_is_write;
    assign eng_rd    = w_accept && !cmd_is_write;
    assign eng_addr  = w_accept ? cmd_addr : r_addr;
    assign eng_wdata = w_accept ? cmd_data : r_data;
    assign rd_valid  = r_hold && !r_is_write;
    assign rdata     = eng_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold     <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_hold <= w_accept;
            if (w_accept) begin
                r_is_write <= cmd_is_write;
                r_addr     <= cmd_addr;
                r_data     <= cmd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : crc_job_sequencer
//  Purpose  : round-robin job sequencer driving the CRC32C engine register port
//  Revision : 1.0
// ============================================================================
module crc_job_sequencer
    import crc_eng_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BYTES = 250,
    parameter int PUT_GAP   = 2,
    parameter int POLL_MAX  = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_len,
    input  logic [8*NREQ-1:0] din,
    input  logic [NREQ-1:0]   din_valid,
    output logic [NREQ-1:0]   din_ready,
    output logic [NREQ-1:0]   done,
    output logic [31:0]       crc_out,
    output logic              err,
    output logic [15:0]       eng_addr,
    output logic [31:0]       eng_wdata,
    output logic              eng_wr,
    output logic              eng_rd,
    input  logic [31:0]       eng_rdata
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (PUT_GAP > 1) ? $clog2(PUT_GAP) : 1;
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    seq_state_t     r_state, w_next;
    logic [OW-1:0]  r_owner, r_ptr, w_win, w_ptr_next;
    logic [7:0]     r_remain, r_byte, w_len, w_din;
    logic [GW-1:0]  r_gap;
    logic [PW-1:0]  r_polls;
    logic [31:0]    r_status, r_crc;
    logic           r_err, r_got;
    logic           w_found, w_len_ok, w_dvalid, w_poll_last;
    logic [NREQ-1:0] w_rot;

    logic        cmd_valid, cmd_ready, cmd_is_write, rd_valid;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data, rdata;

    crc_bus_master u_bus (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is_write (cmd_is_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rd_valid     (rd_valid),
        .rdata        (rdata),
        .eng_addr     (eng_addr),
        .eng_wdata    (eng_wdata),
        .eng_wr       (eng_wr),
        .eng_rd       (eng_rd),
        .eng_rdata    (eng_rdata)
    );

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_ptr_next = r_ptr;
        w_rot      = NREQ'({req, req} >> r_ptr);
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found    = 1'b1;
                w_win      = OW'(wrap_idx(int'(r_ptr) + k, NREQ));
                w_ptr_next = OW'(wrap_idx(int'(r_ptr) + k + 1, NREQ));
            end
        end
    end

    always_comb begin
        w_len     = '0;
        w_din     = '0;
        w_dvalid  = 1'b0;
        done      = '0;
        din_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == w_win) w_len = req_len[i*8 +: 8];
            if (OW'(i) == r_owner) begin
                w_din        = din[i*8 +: 8];
                w_dvalid     = din_valid[i];
                done[i]      = (r_state == ST_DONE);
                din_ready[i] = (r_state == ST_IN_WAIT) && din_valid[i];
            end
        end
    end

    assign w_len_ok    = (w_len != 8'd0) && (w_len <= 8'(MAX_BYTES));
    assign w_poll_last = (r_polls == PW'(POLL_MAX - 1));
    assign err         = (r_state == ST_DONE) && r_err;
    assign crc_out     = r_crc;

    always_comb begin
        w_next       = r_state;
        cmd_valid    = 1'b0;
        cmd_is_write = 1'b1;
        cmd_addr     = '0;
        cmd_data     = '0;
        case (r_state)
            ST_IDLE:     if (w_found) w_next = w_len_ok ? ST_CLR_WR : ST_DONE;
            ST_CLR_WR: begin
                cmd_valid = 1'b1;
                cmd_addr  = ADDR_CTRL;
                cmd_data  = CTRL_CLR;
                if (cmd_ready) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == '0)
                    w_next = r_got ? ST_POLL_RD : ((r_remain != 8'd0) ? ST_IN_WAIT : ST_GET_WR);
            end
            ST_IN_WAIT:  if (w_dvalid) w_next = ST_IN_WR;
            ST_IN_WR: begin
                cmd_valid = 1'b1;
                cmd_addr  = ADDR_IN;
                cmd_data  = {24'b0, r_byte};
                if (cmd_ready) w_next = ST_PUT_WR;
            end
            ST_PUT_WR: begin
                cmd_valid = 1'b1;
                cmd_addr  = ADDR_CTRL;
                cmd_data  = CTRL_PUT;
                if (cmd_ready) w_next = ST_GAP;
            end
            ST_GET_WR: begin
                cmd_valid = 1'b1;
                cmd_addr  = ADDR_CTRL;
                cmd_data  = CTRL_GET;
                if (cmd_ready) w_next = ST_GAP;
            end
            ST_POLL_RD: begin
                cmd_valid    = 1'b1;
                cmd_is_write = 1'b0;
                cmd_addr     = ADDR_STATUS;
                if (rd_valid) w_next = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (r_status == STAT_READY)      w_next = ST_RES_RD;
                else if (r_status == STAT_ERROR) w_next = ST_DONE;
                else if (w_poll_last)            w_next = ST_DONE;
                else                             w_next = ST_POLL_RD;
            end
            ST_RES_RD: begin
                cmd_valid    = 1'b1;
                cmd_is_write = 1'b0;
                cmd_addr     = ADDR_RESULT;
                if (rd_valid) w_next = ST_DONE;
            end
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_remain <= '0;
            r_byte   <= '0;
            r_gap    <= '0;
            r_polls  <= '0;
            r_status <= '0;
            r_crc    <= '0;
            r_err    <= 1'b0;
            r_got    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_win;
                        r_ptr    <= w_ptr_next;
                        r_remain <= w_len;
                        r_polls  <= '0;
                        r_got    <= 1'b0;
                        r_crc    <= '0;
                        r_err    <= !w_len_ok;
                    end
                end
                ST_CLR_WR, ST_PUT_WR: if (cmd_ready) r_gap <= GW'(PUT_GAP - 1);
                ST_GET_WR: begin
                    if (cmd_ready) begin
                        r_gap <= GW'(PUT_GAP - 1);
                        r_got <= 1'b1;
                    end
                end
                ST_GAP:     if (r_gap != '0) r_gap <= r_gap - 1'b1;
                ST_IN_WAIT: begin
                    if (w_dvalid) begin
                        r_byte   <= w_din;
                        r_remain <= r_remain - 8'd1;
                    end
                end
                ST_POLL_RD: if (rd_valid) r_status <= rdata;
                ST_POLL_CHK: begin
                    if (r_status == STAT_ERROR)
                        r_err <= 1'b1;
                    else if (r_status != STAT_READY) begin
                        if (w_poll_last) r_err   <= 1'b1;
                        else             r_polls <= r_polls + 1'b1;
                    end
                end
                ST_RES_RD:  if (rd_valid) r_crc <= rdata;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_job_sequencer
//  Purpose  : self-checking bench with CRC32C engine model and requester feeders
//  Revision : 1.0
// ============================================================================
module tb_crc_job_sequencer;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_len = '0;
    logic [15:0] din = '0;
    logic [1:0]  din_valid = '0;
    logic [1:0]  din_ready, done;
    logic [31:0] crc_out, eng_wdata;
    logic        err, eng_wr, eng_rd;
    logic [15:0] eng_addr;
    logic [31:0] eng_rdata = '0;

    crc_job_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .done(done), .crc_out(crc_out), .err(err),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_wr(eng_wr),
        .eng_rd(eng_rd), .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    // Reflected CRC32C (0x82F63B78 is 0x1EDC6F41 bit-reversed), one byte.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'b0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'h82F63B78) : (r >> 1);
        return r;
    endfunction

    logic [7:0] job_bytes [256];

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) c = crc_step(c, job_bytes[i]);
        return ~c;
    endfunction

    // Requester feeders: bench fills feed_mem/wr_cnt, feeder consumes on din_ready.
    logic [7:0] feed_mem [2][4096];
    int wr_cnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_cnt[i] < wr_cnt[i] && $urandom_range(0, 3) != 0) begin
                din[i*8 +: 8] = feed_mem[i][rd_cnt[i]];
                din_valid[i]  = 1'b1;
            end else begin
                din[i*8 +: 8] = 8'($urandom);
                din_valid[i]  = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) if (din_ready[i]) rd_cnt[i]++;
    end

    // Engine model: 0 = ready after a few busy polls, 1 = error, 2 = never ready.
    int eng_mode = 0;
    int busy_left = 0;
    int n_wr = 0, n_rd = 0, n_in = 0, n_put = 0, n_get = 0, n_clr = 0, n_stat = 0;
    int n_both = 0, n_pair_err = 0;
    bit last_in = 1'b0, first_pending = 1'b1;
    logic [15:0] first_addr = '0;
    logic [31:0] first_data = '0;
    logic [7:0]  m_in = '0;
    logic [7:0]  m_buf [$];
    logic [31:0] m_result = '0;

    always @(posedge clk) begin
        if (done != 2'b00) first_pending = 1'b1;
        if (eng_wr && eng_rd) n_both++;
        if (eng_wr) begin
            n_wr++;
            if (first_pending) begin
                first_addr    = eng_addr;
                first_data    = eng_wdata;
                first_pending = 1'b0;
            end
            if (eng_addr == 16'h0640) begin
                m_in = eng_wdata[7:0];
                n_in++;
                last_in = 1'b1;
            end else if (eng_addr == 16'h0658) begin
                case (eng_wdata)
                    32'd1: begin
                        if (!last_in) n_pair_err++;
                        m_buf.push_back(m_in);
                        n_put++;
                    end
                    32'd2: begin
                        m_result = 32'hFFFF_FFFF;
                        foreach (m_buf[i]) m_result = crc_step(m_result, m_buf[i]);
                        m_result  = ~m_result;
                        busy_left = $urandom_range(0, 4);
                        n_get++;
                    end
                    32'd3: begin
                        m_buf.delete();
                        n_clr++;
                    end
                    default: n_pair_err++;
                endcase
                last_in = 1'b0;
            end else n_pair_err++;
        end
        if (eng_rd) begin
            n_rd++;
            if (eng_addr == 16'h0648) begin
                n_stat++;
                if (eng_mode == 1)      eng_rdata <= 32'd4;
                else if (eng_mode == 2) eng_rdata <= 32'($urandom_range(0, 2));
                else if (busy_left > 0) begin
                    busy_left--;
                    eng_rdata <= 32'($urandom_range(0, 2));
                end else eng_rdata <= 32'd3;
            end else if (eng_addr == 16'h0650) eng_rdata <= m_result;
            else eng_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output logic [1:0] d, output logic [31:0] c, output logic e);
        bit got = 1'b0;
        int cyc = 0;
        d = '0; c = '0; e = 1'b0;
        while (!got && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            if (done != 2'b00) begin
                got = 1'b1;
                d = done; c = crc_out; e = err;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_crc"}, crc_out, 32'd0);
        check({tag, "_rdy"}, 32'(din_ready), 32'd0);
        check({tag, "_strb"}, {30'b0, eng_wr, eng_rd}, 32'd0);
        check({tag, "_addr"}, 32'(eng_addr), 32'd0);
        check({tag, "_wdat"}, eng_wdata, 32'd0);
    endtask

    task automatic run_job(input int who, input int len, input int mode,
                           input string tag, output logic [31:0] c_obs);
        logic [1:0]  d;
        logic        e;
        bit          ok;
        logic [31:0] exp_crc;
        int s_in, s_put, s_get, s_clr, s_stat, s_acc, s_rd0, s_rd1;
        ok      = (len >= 1 && len <= 250);
        exp_crc = (ok && mode == 0) ? ref_crc(len) : 32'd0;
        eng_mode = mode;
        s_in = n_in; s_put = n_put; s_get = n_get; s_clr = n_clr; s_stat = n_stat;
        s_acc = n_wr + n_rd; s_rd0 = rd_cnt[0]; s_rd1 = rd_cnt[1];
        if (ok) for (int i = 0; i < len; i++) begin
            feed_mem[who][wr_cnt[who]] = job_bytes[i];
            wr_cnt[who]++;
        end
        req_len[who*8 +: 8] = 8'(len);
        req[who] = 1'b1;
        wait_done(d, c_obs, e);
        req[who] = 1'b0;
        check({tag, "_owner"}, 32'(d), 32'(2'b01 << who));
        check({tag, "_crc"}, c_obs, exp_crc);
        check({tag, "_err"}, 32'(e), (ok && mode == 0) ? 32'd0 : 32'd1);
        check({tag, "_rdy_own"}, 32'((who == 0) ? rd_cnt[0] - s_rd0 : rd_cnt[1] - s_rd1), ok ? 32'(len) : 32'd0);
        check({tag, "_rdy_oth"}, 32'((who == 0) ? rd_cnt[1] - s_rd1 : rd_cnt[0] - s_rd0), 32'd0);
        if (ok) begin
            check({tag, "_n_in"}, 32'(n_in - s_in), 32'(len));
            check({tag, "_n_put"}, 32'(n_put - s_put), 32'(len));
            check({tag, "_n_clr"}, 32'(n_clr - s_clr), 32'd1);
            check({tag, "_n_get"}, 32'(n_get - s_get), 32'd1);
        end else begin
            check({tag, "_no_bus"}, 32'(n_wr + n_rd - s_acc), 32'd0);
        end
        if (mode == 2) check({tag, "_polls"}, 32'(n_stat - s_stat), 32'd4095);
        eng_mode = 0;
    endtask

    initial begin
        logic [1:0]  d;
        logic [31:0] c;
        logic        e;
        int          s0;
        bit          hit;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        // Both requesters held: grants alternate 0,1,0.
        for (int i = 0; i < 2; i++) begin
            feed_mem[0][wr_cnt[0]] = 8'h00; wr_cnt[0]++;
        end
        feed_mem[1][wr_cnt[1]] = 8'h00; wr_cnt[1]++;
        req_len = {8'd1, 8'd1};
        req = 2'b11;
        wait_done(d, c, e);
        check("rr1_owner", 32'(d), 32'd1);
        check("rr1_crc", c, 32'h527D5351);
        wait_done(d, c, e);
        req[1] = 1'b0;
        check("rr2_owner", 32'(d), 32'd2);
        check("rr2_crc", c, 32'h527D5351);
        wait_done(d, c, e);
        req[0] = 1'b0;
        check("rr3_owner", 32'(d), 32'd1);
        check("rr3_crc", c, 32'h527D5351);
        check("rr3_err", 32'(e), 32'd0);

        for (int i = 0; i < 9; i++) job_bytes[i] = 8'(8'h31 + i);
        run_job(0, 9, 0, "ascii9", c);
        check("ascii9_known", c, 32'hE3069283);

        run_job(1, 0, 0, "len0", c);
        run_job(1, 251, 0, "len251", c);

        for (int i = 0; i < 3; i++) job_bytes[i] = 8'($urandom);
        run_job(0, 3, 1, "engerr", c);
        for (int i = 0; i < 4; i++) job_bytes[i] = 8'($urandom);
        run_job(1, 4, 0, "after_err", c);
        check("after_err_first_addr", 32'(first_addr), 32'h0658);
        check("after_err_first_data", first_data, 32'd3);

        for (int i = 0; i < 2; i++) job_bytes[i] = 8'($urandom);
        run_job(0, 2, 2, "timeout", c);

        for (int j = 0; j < 6; j++) begin
            int who, len;
            who = $urandom_range(0, 1);
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) job_bytes[i] = 8'($urandom);
            run_job(who, len, 0, "rand", c);
        end

        for (int i = 0; i < 250; i++) job_bytes[i] = 8'($urandom);
        run_job(1, 250, 0, "max250", c);

        // Abort a 5-byte job with reset while its third byte is pending.
        for (int i = 0; i < 5; i++) begin
            feed_mem[0][wr_cnt[0]] = 8'($urandom); wr_cnt[0]++;
        end
        s0  = rd_cnt[0];
        hit = 1'b0;
        req_len[7:0] = 8'd5;
        req[0] = 1'b1;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(posedge clk); #1;
            if (rd_cnt[0] - s0 == 2) hit = 1'b1;
        end
        check("abort_reached_byte3", 32'(hit), 32'd1);
        reset = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        wr_cnt[0] = rd_cnt[0];
        check_idle_outputs("abort");
        @(posedge clk); #1;
        check("abort_no_done", 32'(done), 32'd0);
        job_bytes[0] = 8'h00;
        run_job(0, 1, 0, "post_abort", c);
        check("post_abort_known", c, 32'h527D5351);

        check("no_wr_rd_overlap", 32'(n_both), 32'd0);
        check("in_put_pairing", 32'(n_pair_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
